// File: rtl/replica_sched_pkg.sv
// ---------------------------------------------------------------------------
// replica_sched_pkg
// Shared types for the replica-exchange sequencer.
//   opt_command_t : even/odd pairing parity handed to the opt datapath
//   sched_state_t : sequencer FSM states, fixed 3-bit encoding
//   flip_command  : helper returning the opposite pairing parity
// ---------------------------------------------------------------------------
package replica_sched_pkg;

   typedef enum logic {
      OR0 = 1'b0,
      OR1 = 1'b1
   } opt_command_t;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      OPT_ISSUE = 3'd1,
      OPT_WAIT  = 3'd2,
      TEST      = 3'd3,
      EXCH      = 3'd4,
      XFER      = 3'd5,
      FIN       = 3'd6,
      SHIFT     = 3'd7
   } sched_state_t;

   function automatic opt_command_t flip_command(input opt_command_t cmd);
      return (cmd == OR0) ? OR1 : OR0;
   endfunction

endpackage

// File: rtl/replica_sched.sv
// ---------------------------------------------------------------------------
// replica_sched
// Top-level sequencer for the replica-exchange array. Each iteration issues
// one optimization sweep, waits for it, pulses the exchange test, latches the
// exchange command, holds a fixed transfer window and flips the pairing
// parity. In idle it can instead run the replica-order shift.
//
// Ports
//   clk, reset        : clock, asynchronous active-low reset
//   start, abort      : run control (start sampled in IDLE only)
//   iter_num          : iterations to run, captured on an accepted start
//   opt_start/opt_done: sweep launch pulse / sweep complete pulse
//   replica_run       : replicas register their exchange test result
//   exchange_run      : replicas latch the exchange command
//   exchange_valid    : exchange window, first transfer cycle only
//   opt_command       : pairing parity (OR0/OR1), persists across runs
//   shift_req         : request an ordering shift (sampled in IDLE only)
//   exchange_shift_d  : ordering shift enable, replica_num cycles
//   busy, done        : not idle / one-cycle run completion pulse
//   iter_cnt          : completed iterations of the current run
// ---------------------------------------------------------------------------
module replica_sched
   import replica_sched_pkg::*;
#(
   parameter int replica_num = 32,
   parameter int xfer_len    = 8,
   parameter int CW          = 24
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic [CW-1:0] iter_num,
   output logic          opt_start,
   input  logic          opt_done,
   output logic          replica_run,
   output logic          exchange_run,
   output logic          exchange_valid,
   output opt_command_t  opt_command,
   input  logic          shift_req,
   output logic          exchange_shift_d,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] iter_cnt
);

   localparam int XW = $clog2(xfer_len + 1);
   localparam int SW = $clog2(replica_num + 1);
   localparam logic [XW-1:0] XFER_LAST  = XW'(xfer_len - 1);
   localparam logic [SW-1:0] SHIFT_LAST = SW'(replica_num - 1);

   sched_state_t  state;
   logic [XW-1:0] xfer_cnt;
   logic [SW-1:0] shift_cnt;
   logic [CW-1:0] iter_target;

   // Sequencer FSM. Every output is a flop set on the transition into the
   // state that owns it, so pulses line up with the state they belong to.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= IDLE;
         xfer_cnt         <= '0;
         shift_cnt        <= '0;
         iter_target      <= '0;
         iter_cnt         <= '0;
         opt_command      <= OR0;
         opt_start        <= 1'b0;
         replica_run      <= 1'b0;
         exchange_run     <= 1'b0;
         exchange_valid   <= 1'b0;
         exchange_shift_d <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         // single-cycle pulses fall unless the transition below re-arms one
         opt_start      <= 1'b0;
         replica_run    <= 1'b0;
         exchange_run   <= 1'b0;
         exchange_valid <= 1'b0;
         done           <= 1'b0;
         if (abort && (state != IDLE)) begin
            // abandon the run: parity and iteration count keep their values
            state            <= IDLE;
            busy             <= 1'b0;
            exchange_shift_d <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     // start has priority; a simultaneous shift_req is dropped
                     iter_target <= iter_num;
                     iter_cnt    <= '0;
                     busy        <= 1'b1;
                     if (iter_num == '0) begin
                        state <= FIN;
                        done  <= 1'b1;
                     end else begin
                        state     <= OPT_ISSUE;
                        opt_start <= 1'b1;
                     end
                  end else if (shift_req) begin
                     state            <= SHIFT;
                     shift_cnt        <= '0;
                     busy             <= 1'b1;
                     exchange_shift_d <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
               OPT_ISSUE: state <= OPT_WAIT;
               OPT_WAIT: begin
                  if (opt_done) begin
                     state       <= TEST;
                     replica_run <= 1'b1;
                  end else begin
                     state <= OPT_WAIT;
                  end
               end
               TEST: begin
                  state        <= EXCH;
                  exchange_run <= 1'b1;
               end
               EXCH: begin
                  // exchange_valid marks only the first transfer cycle
                  state          <= XFER;
                  xfer_cnt       <= '0;
                  exchange_valid <= 1'b1;
               end
               XFER: begin
                  if (xfer_cnt == XFER_LAST) begin
                     opt_command <= flip_command(opt_command);
                     iter_cnt    <= iter_cnt + CW'(1'b1);
                     if ((iter_cnt + CW'(1'b1)) == iter_target) begin
                        state <= FIN;
                        done  <= 1'b1;
                     end else begin
                        state     <= OPT_ISSUE;
                        opt_start <= 1'b1;
                     end
                  end else begin
                     xfer_cnt <= xfer_cnt + XW'(1'b1);
                  end
               end
               FIN: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               SHIFT: begin
                  if (shift_cnt == SHIFT_LAST) begin
                     state            <= IDLE;
                     busy             <= 1'b0;
                     exchange_shift_d <= 1'b0;
                  end else begin
                     shift_cnt <= shift_cnt + SW'(1'b1);
                  end
               end
               default: begin
                  state            <= IDLE;
                  busy             <= 1'b0;
                  exchange_shift_d <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
